// File: rtl/bit_logic_unit_seq.sv
// rtl/bit_logic_unit_seq.sv - multi-cycle chunked bitwise logic unit with zero/parity flags
module bit_logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             parity
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // A partial trailing chunk would leave result bits undefined, so refuse to build.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("bit_logic_unit_seq: WIDTH must be a positive multiple of CHUNK");
  end

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_parity;

  int               w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_res_chunk;
  logic [WIDTH-1:0] w_work_next;

  // Evaluate the selected op on the current chunk and merge it into the work word.
  always_comb begin
    w_base      = int'(r_cnt) * CHUNK;
    w_a_chunk   = r_a[w_base +: CHUNK];
    w_b_chunk   = r_b[w_base +: CHUNK];
    w_res_chunk = '0;
    case (r_op)
      3'b000:  w_res_chunk = ~w_a_chunk;
      3'b001:  w_res_chunk = w_a_chunk & w_b_chunk;
      3'b010:  w_res_chunk = w_a_chunk | w_b_chunk;
      3'b011:  w_res_chunk = w_a_chunk ^ w_b_chunk;
      3'b100:  w_res_chunk = ~(w_a_chunk & w_b_chunk);
      3'b101:  w_res_chunk = ~(w_a_chunk | w_b_chunk);
      3'b110:  w_res_chunk = ~(w_a_chunk ^ w_b_chunk);
      default: w_res_chunk = w_a_chunk;
    endcase
    w_work_next                   = r_work;
    w_work_next[w_base +: CHUNK]  = w_res_chunk;
  end

  // Sequencer: latch operands on start, walk the chunks, publish the result once complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_out    <= '0;
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_work_next;
          if (r_cnt == LAST_CNT) begin
            // Flags come from the just-completed word, not the stale output register.
            r_out    <= w_work_next;
            r_zero   <= (w_work_next == '0);
            r_parity <= ^w_work_next;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign out    = r_out;
  assign zero   = r_zero;
  assign parity = r_parity;

endmodule

// File: tb/tb_bit_logic_unit_seq.sv
// tb/tb_bit_logic_unit_seq.sv - directed self-checking bench for bit_logic_unit_seq
module tb_bit_logic_unit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       zero;
  logic       parity;

  logic       start8;
  logic [2:0] op8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] out8;
  logic       zero8;
  logic       parity8;

  int n_checks;
  int n_errors;

  bit_logic_unit_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .zero(zero), .parity(parity)
  );

  bit_logic_unit_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .out(out8), .zero(zero8), .parity(parity8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return x ^ y;
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  task automatic run_and_check(input string tag, input logic [2:0] o, input logic [7:0] av,
                               input logic [7:0] bv, input logic [7:0] exp, input logic [7:0] prev);
    int bc;
    int overlap;
    bit seen;
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
    a = ~av; b = ~bv;
    check({tag, "_held"}, 32'(out), 32'(prev));
    bc = 0; overlap = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy) bc++;
      if (busy && done) overlap++;
      if (done) seen = 1'b1;
      else tick();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd4);
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_out"}, 32'(out), 32'(exp));
    check({tag, "_zero"}, 32'(zero), 32'(exp == 8'h00));
    check({tag, "_parity"}, 32'(parity), 32'(^exp));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_out_hold"}, 32'(out), 32'(exp));
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] av;
    logic [7:0] bv;
    logic [7:0] e;
    int dones;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_parity", 32'(parity), 32'd0);
    check("rst8_out", 32'(out8), 32'd0);
    rst_n = 1'b1;
    tick();

    run_and_check("not_a5", 3'b000, 8'hA5, 8'h00, 8'h5A, 8'h00);
    run_and_check("and_zero", 3'b001, 8'hF0, 8'h0F, 8'h00, 8'h5A);
    run_and_check("xor_fe", 3'b011, 8'hFF, 8'h01, 8'hFE, 8'h00);
    prev = 8'hFE;

    for (int o = 0; o < 8; o++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      e  = ref_op(3'(o), av, bv);
      run_and_check($sformatf("sweep_op%0d", o), 3'(o), av, bv, e, prev);
      prev = e;
    end

    start = 1'b1; op = 3'b000; a = 8'hC3; b = 8'h00;
    tick();
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) a = 8'h00;
      if (done) begin
        dones++;
        check("midrun_a_out", 32'(out), 32'h3C);
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("midrun_one_done", 32'(dones), 32'd1);

    start = 1'b1; op = 3'b001; a = 8'hFF; b = 8'hFF;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    check("abort_parity", 32'(parity), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      tick();
    end
    check("abort_no_done", 32'(dones), 32'd0);

    start8 = 1'b1; op8 = 3'b110; a8 = 8'h3C; b8 = 8'h3C;
    tick();
    start8 = 1'b0;
    check("c8_busy", 32'(busy8), 32'd1);
    check("c8_not_done", 32'(done8), 32'd0);
    tick();
    check("c8_done", 32'(done8), 32'd1);
    check("c8_busy_off", 32'(busy8), 32'd0);
    check("c8_out", 32'(out8), 32'hFF);
    check("c8_zero", 32'(zero8), 32'd0);
    check("c8_parity", 32'(parity8), 32'd0);
    tick();
    check("c8_done_pulse", 32'(done8), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
